chan_dump_ctrl: RTL and testbench

Sequences the readout ("dump") of one channel's 512-entry circular capture RAM to the UART transmitter after a capture completes. Starts at the oldest sample (one past the capture end address), wraps modulo DEPTH, and fetches one RAM word per transmitted byte using a start/done handshake with the transmitter. Sits between the command processor (dump request and channel select), the capture RAMs (read port) and the UART TX.

---
 rtl/chan_dump_ctrl_if.sv | 24 ++
 rtl/chan_dump_ctrl.sv | 154 +++++++++++++++
 tb/tb_chan_dump_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/chan_dump_ctrl_if.sv
// Capture-RAM read port plus UART TX start/done handshake used by chan_dump_ctrl.
// master = the dump controller, slave = the RAM/transmitter side.
interface chan_dump_ctrl_if #(
  parameter int AW = 9,
  parameter int DW = 8
);
  logic          ram_en;
  logic [AW-1:0] ram_addr;
  logic [1:0]    ram_ch;
  logic [DW-1:0] ram_rdata;
  logic [DW-1:0] tx_data;
  logic          tx_start;
  logic          tx_done;

  modport master (
    output ram_en, ram_addr, ram_ch, tx_data, tx_start,
    input  ram_rdata, tx_done
  );

  modport slave (
    input  ram_en, ram_addr, ram_ch, tx_data, tx_start,
    output ram_rdata, tx_done
  );
endinterface

// File: rtl/chan_dump_ctrl.sv
// Reads one channel's circular capture RAM oldest-first and feeds it byte by byte to the UART TX.
// Optional macro DUMP_HDR_EN prepends a two-byte header (8'hA5, channel number) to every dump.
module chan_dump_ctrl #(
  parameter int DEPTH  = 512,
  parameter int AW     = 9,
  parameter int DW     = 8,
  parameter int NUM_CH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dump,
  input  logic [1:0]       ch_sel,
  input  logic [AW-1:0]    trace_end,
  input  logic             cap_busy,
  chan_dump_ctrl_if.master bus,
  output logic             busy,
  output logic             dump_fin,
  output logic             dump_err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    LATCH   = 3'd2,
    SEND    = 3'd3,
    WAIT_TX = 3'd4,
    FIN     = 3'd5
  } state_t;

  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);
  localparam logic [2:0]    NUM_CH_C  = 3'(NUM_CH);

  state_t        state_r;
  logic          ram_en_r;
  logic [AW-1:0] ram_addr_r;
  logic [1:0]    ram_ch_r;
  logic [DW-1:0] tx_data_r;
  logic          tx_start_r;
  logic          busy_r;
  logic          dump_fin_r;
  logic          dump_err_r;
  logic [AW:0]   cnt_r;
  logic [AW:0]   cnt_next_s;
`ifdef DUMP_HDR_EN
  logic [1:0]    hdr_left_r;
`endif

  assign cnt_next_s   = cnt_r + CNT_ONE;
  assign bus.ram_en   = ram_en_r;
  assign bus.ram_addr = ram_addr_r;
  assign bus.ram_ch   = ram_ch_r;
  assign bus.tx_data  = tx_data_r;
  assign bus.tx_start = tx_start_r;
  assign busy         = busy_r;
  assign dump_fin     = dump_fin_r;
  assign dump_err     = dump_err_r;

  // Dump sequencer: state, read address, sample counter and every registered output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      ram_en_r   <= 1'b0;
      ram_addr_r <= '0;
      ram_ch_r   <= 2'd0;
      tx_data_r  <= '0;
      tx_start_r <= 1'b0;
      busy_r     <= 1'b0;
      dump_fin_r <= 1'b0;
      dump_err_r <= 1'b0;
      cnt_r      <= '0;
`ifdef DUMP_HDR_EN
      hdr_left_r <= 2'd0;
`endif
    end else begin
      // Strobes are single-cycle unless a branch below re-asserts them.
      ram_en_r   <= 1'b0;
      tx_start_r <= 1'b0;
      dump_fin_r <= 1'b0;
      dump_err_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (!dump) begin
            state_r <= IDLE;
          end else if (cap_busy || ({1'b0, ch_sel} >= NUM_CH_C)) begin
            dump_err_r <= 1'b1;
            state_r    <= IDLE;
          end else begin
            ram_ch_r   <= ch_sel;
            ram_addr_r <= trace_end + ADDR_ONE;
            cnt_r      <= '0;
            busy_r     <= 1'b1;
`ifdef DUMP_HDR_EN
            tx_data_r  <= DW'(8'hA5);
            tx_start_r <= 1'b1;
            hdr_left_r <= 2'd2;
            state_r    <= SEND;
`else
            ram_en_r   <= 1'b1;
            state_r    <= FETCH;
`endif
          end
        end
        FETCH: begin
          state_r <= LATCH;
        end
        LATCH: begin
          tx_data_r  <= bus.ram_rdata;
          tx_start_r <= 1'b1;
          state_r    <= SEND;
        end
        SEND: begin
          state_r <= WAIT_TX;
        end
        WAIT_TX: begin
          if (!bus.tx_done) begin
            state_r <= WAIT_TX;
`ifdef DUMP_HDR_EN
          end else if (hdr_left_r == 2'd2) begin
            tx_data_r  <= DW'({6'b0, ram_ch_r});
            tx_start_r <= 1'b1;
            hdr_left_r <= 2'd1;
            state_r    <= SEND;
          end else if (hdr_left_r == 2'd1) begin
            hdr_left_r <= 2'd0;
            ram_en_r   <= 1'b1;
            state_r    <= FETCH;
`endif
          end else begin
            cnt_r      <= cnt_next_s;
            ram_addr_r <= ram_addr_r + ADDR_ONE;
            if (cnt_next_s == CNT_DEPTH) begin
              dump_fin_r <= 1'b1;
              busy_r     <= 1'b0;
              state_r    <= FIN;
            end else begin
              ram_en_r <= 1'b1;
              state_r  <= FETCH;
            end
          end
        end
        FIN: begin
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chan_dump_ctrl.sv
// Scoreboard bench for chan_dump_ctrl: expected addresses and bytes are queued when a dump is
// requested and popped as the DUT fetches and transmits. Models the RAM and the UART TX.
module tb_chan_dump_ctrl;
  localparam int DEPTH  = 512;
  localparam int AW     = 9;
  localparam int DW     = 8;
  localparam int NUM_CH = 3;
`ifdef DUMP_HDR_EN
  localparam int HDR = 2;
`else
  localparam int HDR = 0;
`endif

  logic          clk;
  logic          rst;
  logic          dump;
  logic [1:0]    ch_sel;
  logic [AW-1:0] trace_end;
  logic          cap_busy;
  logic          busy;
  logic          dump_fin;
  logic          dump_err;

  chan_dump_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  chan_dump_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .NUM_CH(NUM_CH)) dut (
    .clk       (clk),
    .rst       (rst),
    .dump      (dump),
    .ch_sel    (ch_sel),
    .trace_end (trace_end),
    .cap_busy  (cap_busy),
    .bus       (bus),
    .busy      (busy),
    .dump_fin  (dump_fin),
    .dump_err  (dump_err)
  );

  logic [DW-1:0] mem [4][DEPTH];
  logic [DW-1:0] exp_b [$];
  logic [AW-1:0] exp_a [$];
  int checks = 0;
  int passes = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.ram_en   !== 1'b0) $display("FAIL reset ram_en: got %b, want 0", bus.ram_en);     else passes++;
    checks++; if (bus.ram_addr !== '0)   $display("FAIL reset ram_addr: got %0d, want 0", bus.ram_addr); else passes++;
    checks++; if (bus.ram_ch   !== 2'd0) $display("FAIL reset ram_ch: got %0d, want 0", bus.ram_ch);     else passes++;
    checks++; if (bus.tx_data  !== '0)   $display("FAIL reset tx_data: got %0h, want 0", bus.tx_data);   else passes++;
    checks++; if (bus.tx_start !== 1'b0) $display("FAIL reset tx_start: got %b, want 0", bus.tx_start); else passes++;
    checks++; if (busy         !== 1'b0) $display("FAIL reset busy: got %b, want 0", busy);              else passes++;
    checks++; if (dump_fin     !== 1'b0) $display("FAIL reset dump_fin: got %b, want 0", dump_fin);      else passes++;
    checks++; if (dump_err     !== 1'b0) $display("FAIL reset dump_err: got %b, want 0", dump_err);      else passes++;
    rst = 1'b0;
  endtask

  task automatic test_refusal();
    for (int k = 0; k < 2; k++) begin
      dump      = 1'b1;
      ch_sel    = (k == 0) ? 2'd1 : 2'd3;
      cap_busy  = (k == 0);
      trace_end = 9'd20;
      @(posedge clk); #1;
      dump = 1'b0; cap_busy = 1'b0;
      checks++; if (dump_err   !== 1'b1) $display("FAIL refuse%0d dump_err: got %b, want 1", k, dump_err); else passes++;
      checks++; if (busy       !== 1'b0) $display("FAIL refuse%0d busy: got %b, want 0", k, busy);         else passes++;
      checks++; if (bus.ram_en !== 1'b0) $display("FAIL refuse%0d ram_en: got %b, want 0", k, bus.ram_en); else passes++;
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); #1;
        checks++;
        if ({dump_err, busy, bus.ram_en, bus.tx_start} !== 4'b0000)
          $display("FAIL refuse%0d idle: got err/busy/en/start=%b, want 0000", k, {dump_err, busy, bus.ram_en, bus.tx_start});
        else passes++;
      end
    end
  endtask

  // One full (or reset-aborted) dump with RAM and transmitter models running cycle by cycle.
  task automatic run_dump(input logic [1:0] ch, input logic [AW-1:0] te, input int gap,
                          input int rst_after, input bit poke, input string tag);
    int cyc, cd, done_cnt, start_cnt, last_done_cyc, budget, total;
    bit pend, fin_seen, aborted, stray_done, seen_rd;
    logic [AW-1:0] pend_addr, first_addr, last_addr, a, te_p1;
    logic [1:0] pend_ch;
    logic [DW-1:0] held, eb;
    logic exp_busy;
    total = DEPTH + HDR;
    budget = total * (gap + 4) + 64;
    cyc = 0; cd = 0; done_cnt = 0; start_cnt = 0; last_done_cyc = -10;
    pend = 1'b0; fin_seen = 1'b0; aborted = 1'b0; stray_done = 1'b0; seen_rd = 1'b0;
    pend_addr = '0; pend_ch = 2'd0; first_addr = '0; last_addr = '0; held = '0;
    te_p1 = te + 9'd1;
    exp_b.delete(); exp_a.delete();
`ifdef DUMP_HDR_EN
    exp_b.push_back(8'hA5);
    exp_b.push_back({6'b0, ch});
`endif
    a = te;
    for (int i = 0; i < DEPTH; i++) begin
      a = a + 9'd1;
      exp_a.push_back(a);
      exp_b.push_back(mem[ch][a]);
    end
    dump = 1'b1; ch_sel = ch; trace_end = te; cap_busy = 1'b0;
    @(posedge clk); #1;
    dump = 1'b0;
    while (!fin_seen && !aborted && cyc < budget) begin
      bus.tx_done = 1'b0;
      if (pend) begin
        bus.ram_rdata = mem[pend_ch][pend_addr];
        pend = 1'b0;
      end else begin
        bus.ram_rdata = DW'($urandom);
      end
      exp_busy = !(done_cnt == total && last_done_cyc == cyc - 1);
      checks++; if (busy !== exp_busy) $display("FAIL %s busy: got %b, want %b at cycle %0d", tag, busy, exp_busy, cyc); else passes++;
      checks++; if (dump_err !== 1'b0) $display("FAIL %s dump_err: got %b, want 0 at cycle %0d", tag, dump_err, cyc); else passes++;
      if (dump_fin) begin
        checks++;
        if (done_cnt != total || last_done_cyc != cyc - 1)
          $display("FAIL %s dump_fin: got after %0d tx_done (%0d cycles late), want after %0d (1 cycle)", tag, done_cnt, cyc - last_done_cyc, total);
        else passes++;
        fin_seen = 1'b1;
      end
      if (bus.ram_en) begin
        checks++;
        if (exp_a.size() == 0) $display("FAIL %s extra_fetch: got addr %0d, want no fetch", tag, bus.ram_addr);
        else begin
          a = exp_a.pop_front();
          if (bus.ram_addr !== a) $display("FAIL %s ram_addr: got %0d, want %0d", tag, bus.ram_addr, a); else passes++;
        end
        checks++; if (bus.ram_ch !== ch) $display("FAIL %s ram_ch: got %0d, want %0d", tag, bus.ram_ch, ch); else passes++;
        if (!seen_rd) first_addr = bus.ram_addr;
        seen_rd = 1'b1;
        last_addr = bus.ram_addr;
        pend = 1'b1; pend_addr = bus.ram_addr; pend_ch = bus.ram_ch;
        if (poke && done_cnt >= 20 && !stray_done) begin
          bus.tx_done = 1'b1;
          stray_done = 1'b1;
        end
      end
      if (bus.tx_start) begin
        checks++;
        if (exp_b.size() == 0) $display("FAIL %s extra_byte: got %0h, want no tx_start", tag, bus.tx_data);
        else begin
          eb = exp_b.pop_front();
          if (bus.tx_data !== eb) $display("FAIL %s tx_data[%0d]: got %0h, want %0h", tag, start_cnt, bus.tx_data, eb); else passes++;
        end
        if (start_cnt > HDR) begin
          checks++;
          if (cyc - last_done_cyc != 3) $display("FAIL %s latency: got %0d, want 3", tag, cyc - last_done_cyc); else passes++;
        end
        held = bus.tx_data; cd = gap; start_cnt++;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          checks++;
          if (bus.tx_data !== held) $display("FAIL %s tx_hold: got %0h, want %0h", tag, bus.tx_data, held); else passes++;
          bus.tx_done = 1'b1;
          done_cnt++;
          last_done_cyc = cyc;
        end
      end
      dump = 1'b0;
      if (poke && done_cnt == 10 && last_done_cyc == cyc) begin
        dump = 1'b1; ch_sel = ch ^ 2'd1; trace_end = te + 9'd37; cap_busy = 1'b1;
      end
      if (rst_after > 0 && done_cnt == rst_after && last_done_cyc == cyc - 1) begin
        rst = 1'b1;
        aborted = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    cap_busy = 1'b0; dump = 1'b0; bus.tx_done = 1'b0;
    if (aborted) begin
      checks++; if (busy         !== 1'b0) $display("FAIL %s rst_busy: got %b, want 0", tag, busy);          else passes++;
      checks++; if (bus.tx_start !== 1'b0) $display("FAIL %s rst_tx_start: got %b, want 0", tag, bus.tx_start); else passes++;
      checks++; if (bus.ram_en   !== 1'b0) $display("FAIL %s rst_ram_en: got %b, want 0", tag, bus.ram_en);   else passes++;
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
        bus.tx_done = (i % 3 == 0);
        @(posedge clk); #1;
        checks++;
        if ({busy, bus.tx_start, bus.ram_en} !== 3'b000)
          $display("FAIL %s post_rst_idle: got busy/start/en=%b, want 000", tag, {busy, bus.tx_start, bus.ram_en});
        else passes++;
      end
      bus.tx_done = 1'b0;
    end else begin
      checks++; if (!fin_seen) $display("FAIL %s timeout: got no dump_fin in %0d cycles, want dump_fin", tag, budget); else passes++;
      checks++; if (start_cnt != total) $display("FAIL %s tx_start_count: got %0d, want %0d", tag, start_cnt, total); else passes++;
      checks++; if (done_cnt != total) $display("FAIL %s tx_done_count: got %0d, want %0d", tag, done_cnt, total); else passes++;
      checks++; if (exp_b.size() != 0) $display("FAIL %s bytes_left: got %0d, want 0", tag, exp_b.size()); else passes++;
      checks++; if (exp_a.size() != 0) $display("FAIL %s fetches_left: got %0d, want 0", tag, exp_a.size()); else passes++;
      checks++; if (first_addr !== te_p1) $display("FAIL %s first_addr: got %0d, want %0d", tag, first_addr, te_p1); else passes++;
      checks++; if (last_addr !== te) $display("FAIL %s last_addr: got %0d, want %0d", tag, last_addr, te); else passes++;
      for (int i = 0; i < 4; i++) begin
        checks++;
        if ({busy, dump_fin, bus.ram_en, bus.tx_start} !== 4'b0000)
          $display("FAIL %s idle_after: got busy/fin/en/start=%b, want 0000", tag, {busy, dump_fin, bus.ram_en, bus.tx_start});
        else passes++;
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_basic();
    run_dump(2'd1, 9'd100, 5, 0, 1'b0, "basic");
  endtask

  task automatic test_wrap();
    run_dump(2'd2, 9'd511, 1, 0, 1'b0, "wrap");
  endtask

  task automatic test_back_to_back();
    run_dump(2'd0, 9'd300, 2, 0, 1'b1, "poke");
  endtask

  task automatic test_mid_reset();
    run_dump(2'd1, 9'd50, 1, 200, 1'b0, "abort");
    run_dump(2'd0, 9'd7, 1, 0, 1'b0, "restart");
  endtask

  initial begin
    rst = 1'b1; dump = 1'b0; ch_sel = 2'd0; trace_end = '0; cap_busy = 1'b0;
    bus.tx_done = 1'b0; bus.ram_rdata = '0;
    for (int c = 0; c < 4; c++)
      for (int j = 0; j < DEPTH; j++)
        mem[c][j] = DW'($urandom);
    test_reset();
    test_refusal();
    test_basic();
    test_wrap();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
